// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch/decode/execute/mem/wb,
// handshaking with a variable-latency shared memory and counting retired instructions.
module mips_multicycle_sequencer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [5:0]             opcode,
   input  logic [5:0]             funct,
   input  logic                   flag,
   input  logic                   mem_ready,
   input  logic                   halt_req,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic                   mem_addr_sel,
   output logic                   ir_write,
   output logic                   pc_write,
   output logic                   pc_branch,
   output logic                   reg_write,
   output logic                   reg_dst,
   output logic                   mem_to_reg,
   output logic                   alu_src,
   output logic [1:0]             alu_op,
   output logic [2:0]             state,
   output logic [COUNT_WIDTH-1:0] retired,
   output logic                   fault
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_HALTED  = 3'd6,
      S_FAULT   = 3'd7
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // A stall on the cycle where the counter already holds MEM_TIMEOUT-1 is the timeout cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [5:0]             op_q, op_d;
   logic [7:0]             wait_q, wait_d;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;
   logic                   retire_s;
   logic                   enter_fetch_s;
   logic                   unused_funct_s;

   assign unused_funct_s = ^funct;

   // Next-state, wait-counter and retirement logic.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_d        = wait_q;
      retire_s      = 1'b0;
      enter_fetch_s = 1'b0;
      case (state_q)
         S_IDLE: enter_fetch_s = 1'b1;
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
               wait_d  = 8'd0;
            end else if (wait_q == TIMEOUT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_HALT:                                          state_d = S_HALTED;
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI:  state_d = S_EXECUTE;
               default:                                          state_d = S_FAULT;
            endcase
         end
         S_EXECUTE: begin
            case (op_q)
               OP_RTYPE, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW: begin
                  state_d = S_MEM;
                  wait_d  = 8'd0;
               end
               OP_BEQ, OP_BNE: begin
                  retire_s      = 1'b1;
                  enter_fetch_s = 1'b1;
               end
               default: state_d = S_FAULT;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               wait_d = 8'd0;
               if (op_q == OP_SW) begin
                  retire_s      = 1'b1;
                  enter_fetch_s = 1'b1;
               end else if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (wait_q == TIMEOUT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            retire_s      = 1'b1;
            enter_fetch_s = 1'b1;
         end
         S_HALTED: state_d = S_HALTED;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_FAULT;
      endcase

      // Instruction boundary: a pending halt request diverts the fetch.
      if (enter_fetch_s) begin
         wait_d  = 8'd0;
         state_d = halt_req ? S_HALTED : S_FETCH;
      end else begin
         wait_d = wait_d;
      end

      if (retire_s && !(&retired_q)) begin
         retired_d = retired_q + COUNT_WIDTH'(1);
      end else begin
         retired_d = retired_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         op_q      <= 6'd0;
         wait_q    <= 8'd0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Control decode from the registered state and latched opcode.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_branch    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src      = 1'b0;
      alu_op       = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         S_EXECUTE: begin
            case (op_q)
               OP_RTYPE: alu_op = 2'b10;
               OP_ADDI, OP_LW, OP_SW: begin
                  alu_op  = 2'b00;
                  alu_src = 1'b1;
               end
               OP_BEQ: begin
                  alu_op    = 2'b01;
                  pc_write  = 1'b1;
                  pc_branch = flag;
               end
               OP_BNE: begin
                  alu_op    = 2'b01;
                  pc_write  = 1'b1;
                  pc_branch = ~flag;
               end
               default: alu_op = 2'b00;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (op_q == OP_SW);
            alu_src      = 1'b1;
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OP_RTYPE);
            mem_to_reg = (op_q == OP_LW);
         end
         default: mem_req = 1'b0;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign fault   = (state_q == S_FAULT);

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several clocks, instead of the single-cycle every-edge update.
- Drives the PC, IR, register-file, ALU and memory enables, and handshakes with a variable-latency shared instruction/data memory.
- Sits beside the datapath, replacing the combinational control unit's role for multi-cycle builds.

Parameters:
- MEM_TIMEOUT, 16: max consecutive cycles waiting for mem_ready before FAULT; legal range 1..255.
- COUNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  6  instruction[31:26] from IR.
- funct  in  6  instruction[5:0] from IR; accepted but unused by FSM.
- flag  in  1  ALU zero flag, valid in EXECUTE.
- mem_ready  in  1  memory completes current request this cycle.
- halt_req  in  1  request to stop at the next instruction boundary.
- mem_req  out  1  memory request active.
- mem_we  out  1  write request (valid with mem_req).
- mem_addr_sel  out  1  0 = PC address, 1 = ALU result.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC this edge.
- pc_branch  out  1  with pc_write: 1 = PC+1+imm, 0 = PC+1.
- reg_write  out  1  register file write.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data, 0 = ALU result.
- alu_src  out  1  1 = immediate operand.
- alu_op  out  2  00 add, 01 sub, 10 use funct.
- state  out  3  current state encoding.
- retired  out  COUNT_WIDTH  retired-instruction count.
- fault  out  1  sticky fault indicator.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- Reset:
  - Any edge with reset_n=0 forces IDLE, clears retired, wait counter, latched opcode and fault. Applies mid-instruction; no memory write is issued after that edge.
  - In IDLE all control outputs are 0.
- IDLE -> FETCH on the first edge with reset_n=1.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, halt 111111. Any other opcode is illegal.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_branch=0 in the same cycle; next state DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE (1 cycle):
  - Latch opcode into op_q.
  - halt -> HALTED; illegal -> FAULT; else EXECUTE.
- EXECUTE (1 cycle):
  - R-type: alu_op=10, alu_src=0 -> WB.
  - addi, lw, sw: alu_op=00, alu_src=1. addi -> WB; lw and sw -> MEM.
  - beq/bne: alu_op=01, alu_src=0, pc_write=1, pc_branch=(beq&flag)|(bne&~flag) -> FETCH; instruction retires.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(op_q==sw). Hold alu_op=00 and alu_src=1.
  - On mem_ready=1: sw retires -> FETCH; lw -> WB.
- WB (1 cycle):
  - reg_write=1, reg_dst=(R-type), mem_to_reg=(lw); retires -> FETCH.
- Wait counter:
  - Cleared on entering FETCH or MEM and on mem_ready=1.
  - Counts cycles with mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - mem_ready=1 on the timeout cycle wins (completes normally).
- Instruction boundary:
  - On any transition into FETCH (from IDLE, EXECUTE, MEM or WB), if halt_req=1 go to HALTED instead. The retiring instruction still counts.
- HALTED and FAULT:
  - Absorbing until reset; all control outputs 0.
  - fault=1 only in FAULT.
- retired increments by 1 per retiring instruction and saturates at all ones.
- Control outputs are Moore decodes of state/op_q, except ir_write/pc_write in FETCH and MEM completion, which also depend on mem_ready and flag.
- Latency with mem_ready tied high:
  - beq/bne: 3 cycles.
  - R-type, addi: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.

Test Plan:
- Reset release, mem_ready=1, IR holding R-type 000000 -> states 0,1,2,3,5,1; reg_write=1 and reg_dst=1 only in WB; retired=1 after 5 edges.
- lw (100011) with mem_ready low 3 cycles in FETCH and 2 in MEM -> no fault; mem_addr_sel=1 only in MEM; mem_to_reg=1 in WB; total 10 cycles.
- beq with flag=1 -> pc_write=1, pc_branch=1 in EXECUTE; bne with flag=1 -> pc_branch=0; each retires in 3 cycles.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=4 -> FAULT after 4 stalled cycles, fault=1, all enables 0; opcode 010101 decoded -> FAULT directly from DECODE.
- sw in MEM stalled, reset_n=0 for one edge -> IDLE, mem_req=0, mem_we=0, retired=0; then restart fetch.
- halt_req=1 during WB of addi -> HALTED instead of FETCH, retired incremented; opcode 111111 also reaches HALTED, retired unchanged.
